// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, aluop classes and funct constants shared by the issue stage
package alu_pkg;

  typedef logic [2:0] alu_ctrl_t;

  // ALU control codes consumed directly by the EX-stage ALU
  localparam alu_ctrl_t ALU_ADD = 3'b010;
  localparam alu_ctrl_t ALU_SUB = 3'b110;
  localparam alu_ctrl_t ALU_AND = 3'b000;
  localparam alu_ctrl_t ALU_OR  = 3'b001;
  localparam alu_ctrl_t ALU_SLT = 3'b111;
  localparam alu_ctrl_t ALU_X   = 3'b011;

  // A bubble is an add of 0+0 so the ALU reports zero=1 and a defined result
  localparam alu_ctrl_t ALU_BUBBLE = ALU_ADD;

  // Main-control op classes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_UNDEF = 2'b11;

  // R-type funct fields understood by the ALU
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  function automatic logic is_undef(input alu_ctrl_t ctrl);
    return (ctrl == ALU_X);
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - combinational aluop/funct to ALU control decoder
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  // Map op class (and funct for R-type) to the ALU control code; unknowns map to ALU_X
  always_comb begin
    alu_control = ALU_X;
    case (aluop)
      ALUOP_ADD:   alu_control = ALU_ADD;
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_control = ALU_ADD;
          FUNCT_SUB: alu_control = ALU_SUB;
          FUNCT_AND: alu_control = ALU_AND;
          FUNCT_OR:  alu_control = ALU_OR;
          FUNCT_SLT: alu_control = ALU_SLT;
          default:   alu_control = ALU_X;
        endcase
      end
      default:     alu_control = ALU_X;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX issue register for the ALU; optional operand forwarding under ALU_ISSUE_FWD_EN
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [WIDTH-1:0] imm,
  input  logic             alusrc,
  input  logic             stall,
  input  logic             flush,
  input  logic             illegal_clr,
`ifdef ALU_ISSUE_FWD_EN
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_regwrite,
  input  logic [WIDTH-1:0] exmem_result,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  output logic             illegal_op,
  output logic [CNT_W-1:0] issue_count
);

  logic [2:0]       dec_control;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] op_b;
  logic             accept;
  logic             illegal_set;

  alu_ctrl_dec u_dec (
    .aluop       (aluop),
    .funct       (funct),
    .alu_control (dec_control)
  );

`ifdef ALU_ISSUE_FWD_EN
  logic fwd_a;
  logic fwd_b;

  // Take the EX/MEM result when it writes the register being read; r0 is never forwarded
  always_comb begin
    fwd_a = exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs);
    fwd_b = exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rt);
    op_a  = fwd_a ? exmem_result : rd1;
    reg_b = fwd_b ? exmem_result : rd2;
  end
`else
  // Operands come straight from the register file
  always_comb begin
    op_a  = rd1;
    reg_b = rd2;
  end
`endif

  // B mux: the immediate path bypasses forwarding entirely
  always_comb begin
    op_b        = alusrc ? imm : reg_b;
    accept      = !flush && !stall && in_valid;
    illegal_set = accept && is_undef(dec_control);
  end

  // Pipeline register: flush beats stall, stall beats accept, idle loads a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= ALU_BUBBLE;
    end else if (flush) begin
      out_valid   <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= ALU_BUBBLE;
    end else if (stall) begin
      out_valid   <= out_valid;
      alu_a       <= alu_a;
      alu_b       <= alu_b;
      alu_control <= alu_control;
    end else if (in_valid) begin
      out_valid   <= 1'b1;
      alu_a       <= op_a;
      alu_b       <= op_b;
      alu_control <= dec_control;
    end else begin
      out_valid   <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= ALU_BUBBLE;
    end
  end

  // Sticky undefined-op flag; a new set in the same cycle overrides a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_op <= 1'b0;
    end else if (illegal_set) begin
      illegal_op <= 1'b1;
    end else if (illegal_clr) begin
      illegal_op <= 1'b0;
    end
  end

  // Count accepted ops, wrapping silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_count <= '0;
    end else if (accept) begin
      issue_count <= issue_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX boundary stage that feeds the EX-stage ALU.
- Decodes aluop/funct into the 3-bit ALU control code.
- Selects the B operand (register or sign-extended immediate).
- Registers operands and control with stall/flush handling.
- Flags undefined operations and counts issued ALU ops.
- Sits between the decode/register-file logic and the ALU, which consumes alu_a, alu_b and alu_control directly.

Parameters:
- WIDTH, 32, datapath width of operands and immediate.
- CNT_W, 32, width of issue_count (wraps).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  decode stage presents an instruction.
- aluop  in  2  main-control ALU op class.
- funct  in  6  R-type funct field.
- rd1  in  WIDTH  register-file read data 1.
- rd2  in  WIDTH  register-file read data 2.
- imm  in  WIDTH  sign-extended immediate.
- alusrc  in  1  1 = B from imm, 0 = B from rd2.
- stall  in  1  hold stage contents.
- flush  in  1  insert bubble.
- illegal_clr  in  1  clear sticky illegal flag.
- out_valid  out  1  registered op is real (not a bubble).
- alu_a  out  WIDTH  registered ALU operand A.
- alu_b  out  WIDTH  registered ALU operand B.
- alu_control  out  3  registered ALU control code.
- illegal_op  out  1  sticky: an undefined op was issued.
- issue_count  out  CNT_W  number of accepted ops, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, immediate on rst rise): out_valid=0, alu_a=0, alu_b=0, alu_control=010, illegal_op=0, issue_count=0. Reset mid-operation discards the held op; no output glitches to X.
- Decode (combinational): aluop 00 -> 010 (add); 01 -> 110 (sub); 11 -> 011 (ALUx, undefined).
- aluop 10 uses funct:
  - 100000 -> 010 (add)
  - 100010 -> 110 (sub)
  - 100100 -> 000 (and)
  - 100101 -> 001 (or)
  - 101010 -> 111 (slt)
  - any other funct -> 011 (ALUx, undefined)
- Operand B = alusrc ? imm : rd2. Operand A = rd1. No width change; imm arrives already sign-extended.
- Per rising edge, priority order:
  1. flush=1: load bubble (out_valid=0, alu_a=0, alu_b=0, alu_control=010). Flush wins over stall.
  2. stall=1: hold all registered outputs and issue_count unchanged.
  3. in_valid=1: accept; out_valid=1, load operands and decoded control; issue_count+1.
  4. else: load bubble.
- Latency: exactly 1 cycle from accept edge to outputs.
- illegal_op: set on the edge an op with decoded control 011 is accepted. Cleared by illegal_clr when no set occurs that cycle. Set wins over clear in the same cycle. Remains set through subsequent legal ops.
- issue_count wraps from all-ones to 0 without flag.
- Bubble encoding (add of 0+0) guarantees ALU zero=1 and a defined result during bubbles.

Optional Feature:
Macro ALU_ISSUE_FWD_EN.
- When defined, adds these ports:
  - rs  in  5
  - rt  in  5
  - exmem_rd  in  5
  - exmem_regwrite  in  1
  - exmem_result  in  WIDTH
- Forwarding for A: if exmem_regwrite=1, exmem_rd!=0 and exmem_rd==rs, use exmem_result in place of rd1.
- Forwarding for B: if exmem_regwrite=1, exmem_rd!=0 and exmem_rd==rt, use exmem_result in place of rd2. This applies only when alusrc=0; the imm path is never forwarded.
- When not defined: ports absent, operands taken straight from rd1/rd2/imm.

Decomposition:
- Shared package alu_pkg:
  - ALU control codes ALU_ADD=010, ALU_SUB=110, ALU_AND=000, ALU_OR=001, ALU_SLT=111, ALU_X=011.
  - aluop codes.
  - funct constants.
  - bubble control constant.
- One natural sub-module: alu_ctrl_dec, the combinational aluop/funct -> control decoder. It is reusable by verification as a reference decoder.
- Top holds the pipeline registers, flag and counter.

Test Plan:
- rst pulsed mid-cycle while out_valid=1 -> outputs go to out_valid=0, alu_control=010, issue_count=0 immediately, not at next edge.
- in_valid=1, aluop=10, funct=100010, rd1=7, rd2=3, alusrc=0 -> next edge: out_valid=1, alu_a=7, alu_b=3, alu_control=110, issue_count=1.
- aluop=00, alusrc=1, rd1=0x10, imm=0xFFFFFFFC -> alu_b=0xFFFFFFFC, alu_control=010.
- Accept an op, then stall=1 for 2 cycles with different inputs -> outputs and issue_count unchanged. Then stall=1 and flush=1 together -> bubble, out_valid=0.
- aluop=10, funct=000000 -> alu_control=011 and illegal_op=1 next edge. A following legal op keeps illegal_op=1. illegal_clr=1 concurrent with another undefined op -> illegal_op stays 1. illegal_clr alone -> 0.
- With ALU_ISSUE_FWD_EN: rs=5, exmem_rd=5, exmem_regwrite=1, exmem_result=0xAA -> alu_a=0xAA. Same with exmem_rd=0 -> alu_a=rd1.
